// File: rtl/reg16_component_pkg.sv
// Shared datapath definitions.
// Keeps the register file, ALU and muxes agreed on the data word width and
// on the word every register returns to when reset.
package reg16_component_pkg;

  localparam int unsigned DATA_WIDTH = 16;

  localparam logic [DATA_WIDTH-1:0] DEFAULT_RESET_WORD = 16'h0000;

endpackage : reg16_component_pkg

// File: rtl/reg16_component_en_dff.sv
// Single-bit enable flip-flop with asynchronous active-high reset.
// Ports:
//   clock - rising-edge clock
//   reset - asynchronous, active-high; forces q to RESET_BIT immediately
//   d     - data bit to capture
//   en    - capture enable; 1 = load d on the next rising edge, 0 = hold
//   q     - stored bit, driven straight from the flop
module reg16_component_en_dff #(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  input  logic en,
  output logic q
);

  // Storage bit: reset wins over any coincident edge, otherwise load-or-hold.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= RESET_BIT;
    end else if (en) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule : reg16_component_en_dff

// File: rtl/reg16_component.sv
// General-purpose write-enabled datapath register.
// Captures `in` on the rising edge of `clock` when `write` is high, holds
// otherwise, and drives the stored word continuously on `out`. Because `out`
// comes only from flops, registers can be chained out->in on a shared clock
// with exactly one edge of lag per stage.
// Ports:
//   clock - system clock, all updates on its rising edge
//   reset - asynchronous, active-high; out = RESET_VALUE at once
//   in    - WIDTH-bit data word to capture
//   write - write enable; 1 = capture in at next rising edge
//   out   - WIDTH-bit stored word (no combinational path from in)
module reg16_component
  import reg16_component_pkg::*;
#(
  parameter int unsigned           WIDTH       = DATA_WIDTH,
  parameter logic [WIDTH-1:0]      RESET_VALUE = DEFAULT_RESET_WORD
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             write,
  output logic [WIDTH-1:0] out
);

  // One enable flop per bit; each bit picks up its own slice of RESET_VALUE.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    reg16_component_en_dff #(
      .RESET_BIT (RESET_VALUE[i])
    ) u_bit (
      .clock (clock),
      .reset (reset),
      .d     (in[i]),
      .en    (write),
      .q     (out[i])
    );
  end

endmodule : reg16_component

// File: tb/tb_reg16_component.sv
// Directed self-checking bench for reg16_component.
// Two instances (a, b) share clock and reset; b.in is wired to a.out so
// reg-to-reg chaining can be observed. Inputs change and outputs are sampled
// on the falling edge, away from the active rising edge.
module tb_reg16_component;

  logic        clock;
  logic        reset;
  logic [15:0] in_a;
  logic        write_a;
  logic [15:0] out_a;
  logic        write_b;
  logic [15:0] out_b;

  int n_cmp;
  int n_bad;

  reg16_component u_a (
    .clock (clock),
    .reset (reset),
    .in    (in_a),
    .write (write_a),
    .out   (out_a)
  );

  reg16_component u_b (
    .clock (clock),
    .reset (reset),
    .in    (out_a),
    .write (write_b),
    .out   (out_b)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Watchdog so the run always ends.
  initial begin
    #20000;
    $display("FAIL watchdog: timeout reached, required finish before 20000");
    $fatal(1, "timeout");
  end

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance past one rising edge, landing on the following falling edge.
  task automatic step();
    @(negedge clock);
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    reset   = 1'b1;
    write_a = 1'b1;
    write_b = 1'b1;
    in_a    = 16'hFFFF;

    // 1. Reset with write=1 and in=FFFF: 0 immediately, 0 after an edge.
    #1;
    check_val("reset_immediate_a", out_a, 16'h0000);
    check_val("reset_immediate_b", out_b, 16'h0000);
    step();
    check_val("reset_after_edge_a", out_a, 16'h0000);
    check_val("reset_after_edge_b", out_b, 16'h0000);

    // 2. Write 0x0010: unchanged before the edge, new value after.
    reset   = 1'b0;
    write_a = 1'b1;
    write_b = 1'b0;
    in_a    = 16'h0010;
    #1;
    check_val("write_before_edge", out_a, 16'h0000);
    step();
    check_val("write_after_edge", out_a, 16'h0010);
    check_val("write_b_held", out_b, 16'h0000);

    // 3. Hold for 5 edges with write=0 and a different input.
    write_a = 1'b0;
    in_a    = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      step();
      check_val($sformatf("hold_%0d", i), out_a, 16'h0010);
    end

    // 4. Chain: clear a to 0, then write 16 into a with both writes high.
    write_a = 1'b1;
    write_b = 1'b1;
    in_a    = 16'h0000;
    step();
    check_val("chain_prep_a", out_a, 16'h0000);
    check_val("chain_prep_b", out_b, 16'h0010);
    in_a = 16'h0010;
    step();
    check_val("chain_e1_a", out_a, 16'h0010);
    check_val("chain_e1_b", out_b, 16'h0000);
    step();
    check_val("chain_e2_a", out_a, 16'h0010);
    check_val("chain_e2_b", out_b, 16'h0010);
    write_a = 1'b0;
    write_b = 1'b0;
    in_a    = 16'hABCD;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val($sformatf("chain_hold_a_%0d", i), out_a, 16'h0010);
      check_val($sformatf("chain_hold_b_%0d", i), out_b, 16'h0010);
    end

    // 5. Async reset pulse between edges, then an edge with write=0.
    #1;
    reset = 1'b1;
    #1;
    check_val("async_rst_during_a", out_a, 16'h0000);
    check_val("async_rst_during_b", out_b, 16'h0000);
    reset = 1'b0;
    #1;
    check_val("async_rst_after_release", out_a, 16'h0000);
    step();
    check_val("async_rst_next_edge", out_a, 16'h0000);

    // 6. Extremes on consecutive edges; b trails a by one edge.
    write_a = 1'b1;
    write_b = 1'b1;
    in_a    = 16'hFFFF;
    step();
    check_val("extreme_ffff_a", out_a, 16'hFFFF);
    check_val("extreme_ffff_b", out_b, 16'h0000);
    in_a = 16'h0000;
    step();
    check_val("extreme_0000_a", out_a, 16'h0000);
    check_val("extreme_0000_b", out_b, 16'hFFFF);
    step();
    check_val("extreme_tail_b", out_b, 16'h0000);

    // Mid-cycle input change is not visible until the next rising edge.
    in_a = 16'h5A5A;
    #2;
    in_a = 16'hA5A5;
    #1;
    check_val("midcycle_no_pass", out_a, 16'h0000);
    step();
    check_val("midcycle_captured", out_a, 16'hA5A5);

    // Reset asserted exactly at a write edge still leaves RESET_VALUE.
    in_a = 16'h7777;
    @(posedge clock);
    reset = 1'b1;
    #1;
    check_val("reset_at_edge", out_a, 16'h0000);
    @(negedge clock);
    reset = 1'b0;
    write_a = 1'b0;
    step();
    check_val("reset_at_edge_hold", out_a, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_reg16_component
